dmem_store_buffer: RTL

- Write-side companion to the data memory read path.
- Accepts stores from the MEM stage (address from ALU result, data from qb) into a small in-order FIFO.
- Drains the FIFO to the data-memory write port under a ready/ack handshake.
- Forwards buffered data to same-cycle loads, so the combinational read path never returns stale words.

---
 rtl/dmem_store_buffer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer
//
// Write-side store buffer for the data memory. Stores issued by the MEM
// stage are queued in a small in-order FIFO and drained to the data-memory
// write port one per accepted handshake. Loads look up the buffer and receive
// the youngest matching buffered word, so the combinational read path never
// returns data that a pending store has superseded.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   clrn       synchronous active-low reset
//   mwmem      MEM-stage store request
//   mm2reg     MEM-stage load request (forwarding lookup)
//   malu_out   MEM-stage byte address; word address = malu_out[AW+1:2]
//   mqb        store data
//   stall      store cannot be accepted this cycle (buffer full)
//   fwd_hit    load address matches a buffered store
//   fwd_data   data of the youngest matching buffered store, 0 on miss
//   mem_we     write request to data memory (buffer not empty)
//   mem_addr   word address of the head entry
//   mem_wdata  data of the head entry
//   mem_ack    memory accepted the write this cycle
//   empty      no buffered stores
//   count      number of valid entries, 0..DEPTH
module dmem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 8
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic                     mwmem,
    input  logic                     mm2reg,
    input  logic [31:0]              malu_out,
    input  logic [31:0]              mqb,
    output logic                     stall,
    output logic                     fwd_hit,
    output logic [31:0]              fwd_data,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic                     mem_ack,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]  head_reg;
    logic [PW-1:0]  tail_reg;
    logic [CW-1:0]  count_reg;
    logic [DEPTH-1:0] valid_reg;
    logic [AW-1:0]  addr_reg [DEPTH];
    logic [31:0]    data_reg [DEPTH];

    logic [AW-1:0]  word_addr;
    logic           full;
    logic           push;
    logic           pop;
    logic [DEPTH-1:0] match;
    logic [PW-1:0]  age_idx;
    logic           fwd_hit_next;
    logic [31:0]    fwd_data_next;

    // Byte-offset and high address bits play no part in word addressing.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{malu_out[31:AW+2], malu_out[1:0]};

    assign word_addr = malu_out[AW+1:2];
    assign full      = (count_reg == CW'(DEPTH));
    // Push is decided from the occupancy at the start of the cycle, so a pop
    // in the same cycle as a full-buffer store does not let the store in.
    assign push      = mwmem & ~full;
    assign pop       = (count_reg != '0) & mem_ack;

    assign stall     = mwmem & full;
    assign mem_we    = (count_reg != '0);
    assign mem_addr  = addr_reg[head_reg];
    assign mem_wdata = data_reg[head_reg];
    assign empty     = (count_reg == '0);
    assign count     = count_reg;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            valid_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_reg[i] <= '0;
                data_reg[i] <= '0;
            end
        end else begin
            // Head and tail only coincide when empty (no pop) or full (no
            // push), so the two valid updates never target the same entry.
            if (push) begin
                valid_reg[tail_reg] <= 1'b1;
                addr_reg[tail_reg]  <= word_addr;
                data_reg[tail_reg]  <= mqb;
                tail_reg            <= tail_reg + 1'b1;
            end
            if (pop) begin
                valid_reg[head_reg] <= 1'b0;
                head_reg            <= head_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Per-entry address comparators.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match[gi] = valid_reg[gi] & (addr_reg[gi] == word_addr);
        end
    endgenerate

    // Walk entries oldest to youngest; the last hit seen is the youngest
    // store to that word. The popping head entry is still valid here, so it
    // continues to forward during the cycle it drains.
    always_comb begin
        fwd_hit_next  = 1'b0;
        fwd_data_next = '0;
        age_idx       = '0;
        if (mm2reg) begin
            for (int i = 0; i < DEPTH; i++) begin
                age_idx = head_reg + PW'(i);
                if (match[age_idx]) begin
                    fwd_hit_next  = 1'b1;
                    fwd_data_next = data_reg[age_idx];
                end
            end
        end
    end

    assign fwd_hit  = fwd_hit_next;
    assign fwd_data = fwd_data_next;

endmodule
